// File: rtl/serial_parity_pkg.sv
// Shared types and helpers for the serial parity block.
// The CHECK state exists only when PARITY_CHECK_EN is defined.
package serial_parity_pkg;

  localparam int unsigned DEFAULT_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_HOLD  = 2'd1
`ifdef PARITY_CHECK_EN
    ,
    ST_CHECK = 2'd2
`endif
  } state_t;

  // Bit count counter width: max(1, clog2(n)).
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Single-bit 2:1 multiplexer primitive; d1 is selected when sel is high.
module mux2to1 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_xor_cell.sv
// Two-input XOR assembled purely from mux2to1 primitives.
module mux_xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  logic a_n;

  // Inverter: select constant 0 when a is high, constant 1 otherwise.
  mux2to1 u_inv (
    .sel (a),
    .d0  (1'b1),
    .d1  (1'b0),
    .y   (a_n)
  );

  mux2to1 u_sel (
    .sel (b),
    .d0  (a),
    .d1  (a_n),
    .y   (y)
  );

endmodule

// File: rtl/serial_parity_mux.sv
// Serial parity accumulator with valid/ready handshakes on both sides.
// Define PARITY_CHECK_EN to add a trailing check bit per frame and a mismatch flag on out_err.
module serial_parity_mux
  import serial_parity_pkg::*;
#(
  parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter bit          ODD       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clr,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_parity,
  output logic out_err
);

  localparam int unsigned      CNT_W    = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             acc;
  logic             acc_upd;
  logic             acc_nxt;
  logic             xor_y;
  logic             acc_en;
  logic             acc_clr;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Parity datapath: xor cell, enable mux, then clear-to-seed mux.
  mux_xor_cell u_xor (
    .a (acc),
    .b (in_bit),
    .y (xor_y)
  );

  mux2to1 u_en_mux (
    .sel (acc_en),
    .d0  (acc),
    .d1  (xor_y),
    .y   (acc_upd)
  );

  mux2to1 u_clr_mux (
    .sel (acc_clr),
    .d0  (acc_upd),
    .d1  (ODD),
    .y   (acc_nxt)
  );

`ifdef PARITY_CHECK_EN
  logic err;
  logic err_nxt;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
`ifdef PARITY_CHECK_EN
    err_nxt   = err;
`endif
    if (frame_clr) begin
      state_nxt = ST_ACCUM;
      cnt_nxt   = '0;
      acc_clr   = 1'b1;
`ifdef PARITY_CHECK_EN
      err_nxt   = 1'b0;
`endif
    end else begin
      case (state)
        ST_ACCUM: begin
          if (in_fire) begin
            acc_en = 1'b1;
            if (cnt == CNT_LAST) begin
              cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
              state_nxt = ST_CHECK;
`else
              state_nxt = ST_HOLD;
`endif
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
`ifdef PARITY_CHECK_EN
        ST_CHECK: begin
          if (in_fire) begin
            err_nxt   = (in_bit != acc);
            state_nxt = ST_HOLD;
          end
        end
`endif
        ST_HOLD: begin
          if (out_fire) begin
            state_nxt = ST_ACCUM;
            cnt_nxt   = '0;
            acc_clr   = 1'b1;
`ifdef PARITY_CHECK_EN
            err_nxt   = 1'b0;
`endif
          end
        end
        default: begin
          state_nxt = ST_ACCUM;
          cnt_nxt   = '0;
          acc_clr   = 1'b1;
        end
      endcase
    end
  end

  // State register; handshake flags are decoded from the next state so they are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      cnt       <= '0;
      acc       <= ODD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      in_ready  <= (state_nxt != ST_HOLD);
      out_valid <= (state_nxt == ST_HOLD);
    end
  end

  assign out_parity = acc;

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err_nxt;
    end
  end

  assign out_err = err;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_parity_mux.sv
// Scoreboard bench for serial_parity_mux: even/odd FRAME_LEN=8 pair on shared stimulus,
// plus a FRAME_LEN=1 instance exercised with random gaps and backpressure.
module tb_serial_parity_mux;

  logic clk;
  logic rst_n;
  logic frame_clr, in_valid, in_bit, out_ready;
  logic ready_e, valid_e, par_e, err_e;
  logic ready_o, valid_o, par_o, err_o;
  logic frame_clr1, in_valid1, in_bit1, out_ready1;
  logic ready1, valid1, par1, err1;

  int total = 0;
  int bad   = 0;
  int got1  = 0;
  bit rnd_on = 1'b0;

  typedef struct packed {logic pe; logic ee; logic eo;} exp_t;
  typedef struct packed {logic p; logic e;} exp1_t;
  exp_t  q[$];
  exp1_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_parity_mux #(.FRAME_LEN(8), .ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .in_valid(in_valid), .in_ready(ready_e),
    .in_bit(in_bit), .out_valid(valid_e), .out_ready(out_ready), .out_parity(par_e), .out_err(err_e)
  );

  serial_parity_mux #(.FRAME_LEN(8), .ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .in_valid(in_valid), .in_ready(ready_o),
    .in_bit(in_bit), .out_valid(valid_o), .out_ready(out_ready), .out_parity(par_o), .out_err(err_o)
  );

  serial_parity_mux #(.FRAME_LEN(1), .ODD(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr1), .in_valid(in_valid1), .in_ready(ready1),
    .in_bit(in_bit1), .out_valid(valid1), .out_ready(out_ready1), .out_parity(par1), .out_err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the FRAME_LEN=8 pair.
  logic       hp = 1'b0;
  logic [3:0] pv = 4'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hp = 1'b0;
    end else begin
      chk("valid_match", 32'(valid_o), 32'(valid_e));
      chk("ready_match", 32'(ready_o), 32'(ready_e));
      if (valid_e) begin
        chk("hold_in_ready", 32'(ready_e), 32'd0);
        if (hp) chk("hold_stable", 32'({par_e, par_o, err_e, err_o}), 32'(pv));
      end
      if (valid_e && out_ready && !frame_clr) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: result with empty scoreboard at %0t", $time);
        end else begin
          exp_t e;
          logic po;
          e  = q.pop_front();
          po = ~e.pe;
          chk("parity_even", 32'(par_e), 32'(e.pe));
          chk("parity_odd", 32'(par_o), 32'(po));
          chk("err_even", 32'(err_e), 32'(e.ee));
          chk("err_odd", 32'(err_o), 32'(e.eo));
        end
      end
      hp = valid_e && !out_ready && !frame_clr;
      pv = {par_e, par_o, err_e, err_o};
    end
  end

  // Monitor for the FRAME_LEN=1 instance.
  always @(negedge clk) begin
    if (rst_n && valid1) begin
      chk("u1_hold_ready", 32'(ready1), 32'd0);
      if (out_ready1) begin
        if (q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL u1_unexpected_out: result with empty scoreboard at %0t", $time);
        end else begin
          exp1_t e;
          e = q1.pop_front();
          chk("u1_parity", 32'(par1), 32'(e.p));
          chk("u1_err", 32'(err1), 32'(e.e));
          got1++;
        end
      end
    end
  end

  // Random backpressure for the FRAME_LEN=1 instance.
  initial begin
    out_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready1 = rnd_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b);
    int   n;
    logic took;
    n = 0;
    in_valid = 1'b1;
    in_bit   = b;
    do begin
      took = ready_e;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 50);
    in_valid = 1'b0;
    if (!took) begin
      total++;
      bad++;
      $display("FAIL send_timeout: bit not accepted after %0d cycles", n);
    end
  endtask

  task automatic send_bit1(input logic b);
    int   n;
    logic took;
    n = 0;
    in_valid1 = 1'b1;
    in_bit1   = b;
    do begin
      took = ready1;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 50);
    in_valid1 = 1'b0;
    if (!took) begin
      total++;
      bad++;
      $display("FAIL u1_send_timeout: bit not accepted after %0d cycles", n);
    end
  endtask

  // Bit i of f is sent i-th; pe is the hand-computed even parity, c the check bit.
  task automatic send_frame(input logic [7:0] f, input logic pe, input logic c);
    exp_t e;
    e.pe = pe;
`ifdef PARITY_CHECK_EN
    e.ee = (c != pe);
    e.eo = (c == pe);
`else
    e.ee = 1'b0;
    e.eo = 1'b0;
`endif
    for (int i = 0; i < 7; i++) send_bit(f[i]);
    chk("pre_valid", 32'(valid_e), 32'd0);
`ifdef PARITY_CHECK_EN
    send_bit(f[7]);
    chk("pre_valid_check", 32'(valid_e), 32'd0);
    q.push_back(e);
    send_bit(c);
`else
    q.push_back(e);
    send_bit(f[7]);
`endif
    chk("latency", 32'(valid_e), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_clr  = 1'b0;
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    out_ready  = 1'b1;
    frame_clr1 = 1'b0;
    in_valid1  = 1'b0;
    in_bit1    = 1'b0;
    #12;
    chk("rst_in_ready", 32'(ready_e), 32'd1);
    chk("rst_out_valid", 32'(valid_e), 32'd0);
    chk("rst_parity_even", 32'(par_e), 32'd0);
    chk("rst_parity_odd", 32'(par_o), 32'd1);
    chk("rst_err", 32'({err_e, err_o}), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic even frame, back-to-back bits.
    send_frame(8'b0000_1101, 1'b1, 1'b1);
    wait_drain();

    // Output backpressure for three cycles.
    out_ready = 1'b0;
    send_frame(8'b0000_1101, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_valid", 32'(valid_e), 32'd1);
    out_ready = 1'b1;
    wait_drain();

    // Check bit mismatch then match (err meaningful only with the check feature).
    send_frame(8'b0000_0011, 1'b0, 1'b1);
    wait_drain();
    send_frame(8'b0000_0011, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back frames.
    send_frame(8'b1111_1111, 1'b0, 1'b0);
    send_frame(8'b1000_0000, 1'b1, 1'b1);
    send_frame(8'b0000_0000, 1'b0, 1'b0);
    send_frame(8'b1110_1001, 1'b1, 1'b1);
    wait_drain();

    // Abort after five bits with a bit offered in the abort cycle.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    frame_clr = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    chk("clr_in_ready", 32'(ready_e), 32'd1);
    chk("clr_out_valid", 32'(valid_e), 32'd0);
    send_frame(8'b0000_0010, 1'b1, 1'b1);
    wait_drain();

    // Abort in HOLD beats a simultaneous output transfer.
    out_ready = 1'b0;
    send_frame(8'b0000_0001, 1'b1, 1'b1);
    frame_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
    void'(q.pop_back());
    chk("clr_hold_valid", 32'(valid_e), 32'd0);
    chk("clr_hold_ready", 32'(ready_e), 32'd1);
    chk("clr_hold_parity_even", 32'(par_e), 32'd0);
    chk("clr_hold_parity_odd", 32'(par_o), 32'd1);
    send_frame(8'b0000_1101, 1'b1, 1'b1);
    wait_drain();

    // Reset mid-frame.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_ready", 32'(ready_e), 32'd1);
    chk("rst_mid_valid", 32'(valid_e), 32'd0);
    chk("rst_mid_parity_odd", 32'(par_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'b1110_1001, 1'b1, 1'b1);
    wait_drain();

    // Reset while holding a result.
    out_ready = 1'b0;
    send_frame(8'b0000_1101, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    void'(q.pop_back());
    chk("rst_hold_valid", 32'(valid_e), 32'd0);
    chk("rst_hold_ready", 32'(ready_e), 32'd1);
    chk("rst_hold_parity_even", 32'(par_e), 32'd0);
    chk("rst_hold_parity_odd", 32'(par_o), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'b1000_0000, 1'b1, 1'b1);
    wait_drain();

    // FRAME_LEN=1 with random input gaps and output stalls.
    rnd_on = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      logic  b;
      logic  c;
      exp1_t e;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      b   = 1'($urandom);
      c   = 1'($urandom);
      e.p = b;
`ifdef PARITY_CHECK_EN
      e.e = (c != b);
      send_bit1(b);
      q1.push_back(e);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_bit1(c);
`else
      e.e = c & 1'b0;
      q1.push_back(e);
      send_bit1(b);
`endif
    end
    begin
      int n;
      n = 0;
      while (q1.size() != 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
      #1;
      if (q1.size() != 0) begin
        total++;
        bad++;
        $display("FAIL u1_drain_timeout: %0d results still pending", q1.size());
      end
    end
    rnd_on = 1'b0;
    chk("u1_frame_count", 32'(got1), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_parity_mux.md
SERIAL_PARITY_MUX -- requirements
Module: serial_parity_mux

Interface
REQ-001 Parameter FRAME_LEN, default 8: number of data bits per frame; legal range 1..256.
REQ-002 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port frame_clr  input  1  synchronous frame abort.
REQ-006 Port in_valid  input  1  in_bit is valid this cycle.
REQ-007 Port in_ready  output  1  block can accept in_bit this cycle.
REQ-008 Port in_bit  input  1  serial data bit, typically driven by an upstream mux-built gate output.
REQ-009 Port out_valid  output  1  frame result is valid.
REQ-010 Port out_ready  input  1  downstream accepts the result.
REQ-011 Port out_parity  output  1  computed parity bit for the frame.
REQ-012 Port out_err  output  1  parity mismatch flag; meaningful only when PARITY_CHECK_EN is defined.

Function
REQ-013 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready on a rising edge.
REQ-014 States: ACCUM, CHECK (PARITY_CHECK_EN only), HOLD.
REQ-015 ACCUM: in_ready=1, out_valid=0; each accepted bit sets acc <= acc ^ in_bit and cnt <= cnt+1.
REQ-016 ACCUM, bit accepted with cnt==FRAME_LEN-1: go to CHECK if PARITY_CHECK_EN is defined, else HOLD.
REQ-017 CHECK: in_ready=1; the accepted bit p sets err <= (p != acc); state goes to HOLD; acc is unchanged.
REQ-018 HOLD: in_ready=0, out_valid=1, out_parity=acc, out_err=err; all outputs are stable until transfer out.
REQ-019 HOLD, on transfer out: go to ACCUM with acc <= ODD, cnt <= 0, err <= 0.
REQ-020 Latency: out_valid asserts the cycle after the final bit (data or check bit) is accepted.
REQ-021 No new frame bit is accepted in the same cycle as a transfer out.
REQ-022 frame_clr=1 in any state: next state ACCUM, acc <= ODD, cnt <= 0, err <= 0; out_valid drops the next cycle.
REQ-023 frame_clr has priority over simultaneous in and out transfers, and the bit offered that cycle is discarded.
REQ-024 in_valid=0 cycles in ACCUM or CHECK stall without changing state.
REQ-025 cnt width is max(1, clog2(FRAME_LEN)); cnt never exceeds FRAME_LEN-1.
REQ-026 FRAME_LEN=1: a single accepted data bit completes the frame.
REQ-027 out_parity = ODD ^ XOR of all data bits in the frame.

Reset
REQ-028 rst_n low asynchronously forces state ACCUM, acc=ODD, cnt=0, err=0.
REQ-029 Outputs during reset: in_ready=1, out_valid=0, out_parity=ODD, out_err=0.
REQ-030 Reset asserted mid-frame or in HOLD discards the partial frame or result with no output transfer.

Configuration
REQ-031 Macro PARITY_CHECK_EN defined: CHECK state exists; a frame is FRAME_LEN+1 bits and out_err reports a mismatch.
REQ-032 Macro PARITY_CHECK_EN undefined: no CHECK state; a frame is FRAME_LEN bits and out_err is tied to 0.

Structure
REQ-033 Shared package serial_parity_pkg holds the state enum typedef, DEFAULT_FRAME_LEN=8 and the counter-width function.
REQ-034 The acc ^ in_bit update uses sub-module mux_xor_cell, built only from mux2to1 instances, with no behavioural XOR operator.
REQ-035 The acc register enable and the mux_xor_cell output are selected through mux2to1 instances.

Verification
REQ-036 Even parity, FRAME_LEN=8, bits 1,0,1,1,0,0,0,0 sent back-to-back -> out_valid on cycle 9, out_parity=1.
REQ-037 ODD=1, same bit stream, out_ready held low 3 cycles -> out_parity=0 held stable and in_ready=0 throughout HOLD.
REQ-038 PARITY_CHECK_EN, bits 1,1,0,0,0,0,0,0 then check bit 1 -> out_parity=0, out_err=1; check bit 0 -> out_err=0.
REQ-039 frame_clr asserted after 5 bits, together with in_valid=1 -> that bit is discarded; the next 8 bits form a fresh frame with correct parity.
REQ-040 rst_n pulsed low mid-frame and in HOLD -> out_valid=0 immediately, in_ready=1; the next full frame is correct.
REQ-041 FRAME_LEN=1 with random in_valid gaps and out_ready stalls over 1000 frames -> out_parity matches the model; no lost or duplicated frames.
